// File: rtl/rf_wb_arbiter_pkg.sv
// Write-back requester indices and defaults shared between the execute stage and the write-back arbiter.
package rf_wb_arbiter_pkg;
  localparam int WB_ALU  = 0;
  localparam int WB_LSU  = 1;
  localparam int WB_MDU  = 2;
  localparam int WB_NREQ = 3;
  localparam int RIDX_W  = 5;
endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// Round-robin one-hot selector: search begins one past ptr and wraps; purely combinational.
// Grant is zero when no request is present; never stalls.
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);
  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter with pending-write scoreboard; one accepted request per cycle.
// Latency: one cycle from acceptance to rf_we/rf_wr/rf_wd; output drains every cycle so it never backpressures.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NREQ = WB_NREQ,
  parameter int XLEN = 32
) (
  input  logic                   cpu_clk,
  input  logic                   cpu_rstn,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*5-1:0]      req_wr,
  input  logic [NREQ*XLEN-1:0]   req_wd,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   issue_valid,
  input  logic [4:0]             issue_wr,
  output logic                   rf_we,
  output logic [4:0]             rf_wr,
  output logic [XLEN-1:0]        rf_wd,
  output logic [31:0]            busy
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   last_grant;
  logic [PW-1:0]   sel_idx;
  logic [NREQ-1:0] grant;
  logic [4:0]      sel_wr;
  logic [XLEN-1:0] sel_wd;
  logic            acc;
  logic [31:0]     busy_q;
  logic [31:0]     busy_nxt;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req   (req_valid),
    .ptr   (last_grant),
    .grant (grant)
  );

  assign req_ready = cpu_rstn ? grant : '0;
  assign busy      = busy_q;

  // Grant is one-hot, so OR-reduction acts as the data mux.
  always_comb begin
    sel_wr  = '0;
    sel_wd  = '0;
    sel_idx = '0;
    acc     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_wr  = sel_wr | req_wr[i*5 +: 5];
        sel_wd  = sel_wd | req_wd[i*XLEN +: XLEN];
        sel_idx = PW'(i);
        acc     = 1'b1;
      end
    end
  end

  // Set is applied after clear so a fresh producer supersedes a retiring one.
  always_comb begin
    busy_nxt = busy_q;
    if (rf_we)
      busy_nxt[rf_wr] = 1'b0;
    if (issue_valid && issue_wr != 5'd0)
      busy_nxt[issue_wr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rstn) begin
      rf_we      <= 1'b0;
      rf_wr      <= '0;
      rf_wd      <= '0;
      busy_q     <= '0;
      last_grant <= PW'(NREQ - 1);
    end else begin
      busy_q <= busy_nxt;
      rf_we  <= acc && (sel_wr != 5'd0);
      if (acc) begin
        rf_wr      <= sel_wr;
        rf_wd      <= sel_wd;
        last_grant <= sel_idx;
      end
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed scenarios then randomized traffic, checked against a behavioural arbiter/scoreboard model.
module tb_rf_wb_arbiter;
  localparam int NREQ = 3;
  localparam int XLEN = 32;

  logic                 cpu_clk = 1'b0;
  logic                 cpu_rstn;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*5-1:0]    req_wr;
  logic [NREQ*XLEN-1:0] req_wd;
  logic [NREQ-1:0]      req_ready;
  logic                 issue_valid;
  logic [4:0]           issue_wr;
  logic                 rf_we;
  logic [4:0]           rf_wr;
  logic [XLEN-1:0]      rf_wd;
  logic [31:0]          busy;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  int          m_last = NREQ - 1;
  logic        m_we   = 1'b0;
  logic [4:0]  m_wr   = '0;
  logic [31:0] m_wd   = '0;
  logic        m_busy [32];

  always #5 cpu_clk = ~cpu_clk;

  rf_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .cpu_clk     (cpu_clk),
    .cpu_rstn    (cpu_rstn),
    .req_valid   (req_valid),
    .req_wr      (req_wr),
    .req_wd      (req_wd),
    .req_ready   (req_ready),
    .issue_valid (issue_valid),
    .issue_wr    (issue_wr),
    .rf_we       (rf_we),
    .rf_wr       (rf_wr),
    .rf_wd       (rf_wd),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner is the first valid requester found walking upward from last+1, wrapping.
  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [31:0] busy_vec();
    logic [31:0] b;
    for (int i = 0; i < 32; i++) b[i] = m_busy[i];
    return b;
  endfunction

  // Inputs are already applied; check grant mid-cycle, advance model on the edge, check registers after.
  task automatic cycle(input string tag);
    int w;
    logic [NREQ-1:0] exp_rdy;
    w = cpu_rstn ? pick(req_valid, m_last) : -1;
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    @(negedge cpu_clk);
    chk({tag, ".ready"}, 64'(req_ready), 64'(exp_rdy));
    @(posedge cpu_clk);
    if (!cpu_rstn) begin
      m_we = 1'b0; m_wr = '0; m_wd = '0; m_last = NREQ - 1;
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      if (m_we) m_busy[m_wr] = 1'b0;
      if (issue_valid && issue_wr != 0) m_busy[issue_wr] = 1'b1;
      if (w >= 0) begin
        m_wr   = req_wr[w*5 +: 5];
        m_wd   = req_wd[w*XLEN +: XLEN];
        m_we   = (m_wr != 0);
        m_last = w;
      end else begin
        m_we = 1'b0;
      end
    end
    #1;
    chk({tag, ".rf_we"}, 64'(rf_we), 64'(m_we));
    if (m_we) begin
      chk({tag, ".rf_wr"}, 64'(rf_wr), 64'(m_wr));
      chk({tag, ".rf_wd"}, 64'(rf_wd), 64'(m_wd));
    end
    chk({tag, ".busy"}, 64'(busy), 64'(busy_vec()));
  endtask

  task automatic drive(input logic rstn, input logic [NREQ-1:0] v,
                       input logic [NREQ*5-1:0] wr, input logic [NREQ*XLEN-1:0] wd,
                       input logic iv, input logic [4:0] iw, input string tag);
    cpu_rstn    = rstn;
    req_valid   = v;
    req_wr      = wr;
    req_wd      = wd;
    issue_valid = iv;
    issue_wr    = iw;
    cycle(tag);
  endtask

  initial begin
    logic [NREQ-1:0] v;
    logic [NREQ*5-1:0] wr;
    logic [NREQ*XLEN-1:0] wd;
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    cpu_rstn = 1'b0; req_valid = '0; req_wr = '0; req_wd = '0;
    issue_valid = 1'b0; issue_wr = '0;
    #1;

    // Reset, with a valid request present that must not be granted.
    drive(1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1}, 1'b1, 5'd4, "rst0");
    drive(1'b0, 3'b000, '0, '0, 1'b0, 5'd0, "rst1");
    chk("rst.rf_wr", 64'(rf_wr), 64'd0);
    chk("rst.rf_wd", 64'(rf_wd), 64'd0);

    // All requesters valid for six cycles: rotation 0,1,2,0,1,2.
    for (int c = 0; c < 6; c++)
      drive(1'b1, 3'b111, {5'd12, 5'd11, 5'd10}, {32'hC0C0, 32'hB0B0, 32'hA0A0}, 1'b0, 5'd0, "rr");
    drive(1'b1, 3'b000, '0, '0, 1'b0, 5'd0, "idle");

    // Single requester with known payload.
    drive(1'b1, 3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0}, 1'b0, 5'd0, "lsu");
    chk("lsu.wr5", 64'(rf_wr), 64'd5);
    chk("lsu.wdDEADBEEF", 64'(rf_wd), 64'hDEADBEEF);

    // Write to x0 is consumed but suppressed.
    drive(1'b1, 3'b001, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h1234}, 1'b0, 5'd0, "x0");
    chk("x0.we", 64'(rf_we), 64'd0);

    // Issue 7, idle, write 7, then observe clear after the rf_we cycle.
    drive(1'b1, 3'b000, '0, '0, 1'b1, 5'd7, "iss7");
    chk("iss7.busy7", 64'(busy[7]), 64'd1);
    drive(1'b1, 3'b000, '0, '0, 1'b0, 5'd0, "gap7");
    drive(1'b1, 3'b100, {5'd7, 5'd0, 5'd0}, {32'h77, 32'h0, 32'h0}, 1'b0, 5'd0, "wb7");
    chk("wb7.busy7_held", 64'(busy[7]), 64'd1);
    drive(1'b1, 3'b000, '0, '0, 1'b0, 5'd0, "clr7");
    chk("clr7.busy7", 64'(busy[7]), 64'd0);

    // Re-issue of 9 on the edge that retires the old write to 9.
    drive(1'b1, 3'b000, '0, '0, 1'b1, 5'd9, "iss9");
    drive(1'b1, 3'b001, {5'd0, 5'd0, 5'd9}, {32'h0, 32'h0, 32'h99}, 1'b0, 5'd0, "wb9");
    drive(1'b1, 3'b000, '0, '0, 1'b1, 5'd9, "race9");
    chk("race9.busy9", 64'(busy[9]), 64'd1);

    // Reset right after an accepted request drops the in-flight write.
    drive(1'b1, 3'b010, {5'd0, 5'd6, 5'd0}, {32'h0, 32'h66, 32'h0}, 1'b1, 5'd3, "prerst");
    drive(1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1}, 1'b0, 5'd0, "midrst");
    chk("midrst.busy", 64'(busy), 64'd0);
    drive(1'b1, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1}, 1'b0, 5'd0, "postrst");
    chk("postrst.req0_first", 64'(rf_wd), 64'h1);

    // Randomized traffic with occasional reset.
    for (int c = 0; c < 400; c++) begin
      v  = NREQ'($urandom);
      wr = NREQ*5'($urandom);
      wd = {$urandom, $urandom, $urandom};
      drive(($urandom_range(0, 39) != 0), v, wr, wd, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 31)), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
